sram_port_ctrl: RTL and testbench
=================================

# sram_port_ctrl

Single-port request front-end for the OpenRAM 1RW macro (default `sram_2_16_1_freepdk45`). It accepts valid/ready read and write requests from the system side and drives the macro's `csb0`/`web0`/`addr0`/`din0` from registers. It captures `dout0` on the correct clock edge and returns read data through a backpressured response interface. Credit tracking means no read result is ever dropped.

## Interface
- `DATA_WIDTH`, 2: word width; matches the macro.
- `ADDR_WIDTH`, 4: address width; matches the macro.
- `RSP_DEPTH`, 4: response FIFO entries. Minimum 2; 4 or more gives one read per cycle under continuous `rsp_ready`.
- `clk0` in 1: clock shared with the macro; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready` at posedge.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: word address.
- `req_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: consumer takes data when `rsp_valid & rsp_ready` at posedge.
- `rsp_rdata` out DATA_WIDTH: read data, in request order.
- `csb0` out 1: to macro, active-low select.
- `web0` out 1: to macro, active-low write enable.
- `addr0` out ADDR_WIDTH: to macro.
- `din0` out DATA_WIDTH: to macro.
- `dout0` in DATA_WIDTH: from macro.

## Operation
- **Issue stage (registered).**
  - On accept: `csb0`=0, `web0`=~`req_we`, `addr0`=`req_addr`, `din0`=`req_wdata` for exactly one cycle.
  - Idle cycle: `csb0`=1, `web0`=1; `addr0`/`din0` hold their last values.
- **Read tracking.** Two-bit shift `rd_pipe`:
  - `rd_pipe[0]` is set in the cycle a read drives the macro.
  - `rd_pipe[1]` is set one cycle later (the macro has latched the request and `dout0` is settling).
  - At the posedge ending the cycle with `rd_pipe[1]`=1, `dout0` is pushed into the response FIFO.
- **Writes** produce no response and never occupy `rd_pipe`.
- **Credit.** `req_ready` = ~`rst` & (`popcount(rd_pipe)` + `fifo_count` < `RSP_DEPTH`).
  - Independent of `req_valid` and `req_we`.
  - A pop in the current cycle is not credited until the next cycle.
- **FIFO.** First-word-fall-through.
  - `rsp_valid` = FIFO non-empty; `rsp_rdata` = head entry.
  - Simultaneous push and pop is legal at any occupancy, including full, because credit guarantees push never meets a full FIFO.
- **Ordering.** Responses return strictly in read-accept order; interleaved writes do not reorder.
- **Read-after-write, same address, back-to-back.** The macro writes on negedge of its capture cycle and reads on negedge of the next capture cycle, so the read returns the new data. No forwarding logic is added.
- **Reset (synchronous).**
  - `csb0`=1, `web0`=1, `addr0`=0, `din0`=0, `rd_pipe`=0, FIFO empty.
  - `rsp_valid`=0, `rsp_rdata`=0 (masked while empty), `req_ready`=0 while `rst` is high.
  - Asserted mid-operation: in-flight reads and queued responses are discarded. An access already latched by the macro completes inside the macro but its data is never pushed.
  - First accept is possible at the first posedge with `rst` low.
- **Illegal:** `req_*` changing while `req_valid` is high and `req_ready` is low. The bench asserts this; the RTL need not tolerate it.

## Timing
- Read accepted at posedge E0:
  - macro inputs driven during E0→E1;
  - macro captures at E1 and reads at negedge;
  - `dout0` sampled at E2;
  - `rsp_valid` high after E2.
- Read latency: 2 cycles from accept to `rsp_valid`.
- Write accepted at E0: macro captures at E1, array updated at the negedge after E1.
- `dout0` is only valid from E1+negedge+DELAY until E2+T_HOLD. Sampling at exactly E2 is mandatory; sampling at a later edge is wrong.
- Throughput: one request per cycle while credit is available; reads sustain 1/cycle when `RSP_DEPTH` ≥ 4 and `rsp_ready` is held high.

## Structure
- Shared package `sram_ctrl_pkg`: request/response struct typedefs parameterized on widths, and constant `SRAM_RD_LAT` = 2.
- One sub-module: `sram_rsp_fifo`, a synchronous FWFT FIFO with parameters `WIDTH`/`DEPTH` and a `count` output. Credit logic and the issue stage stay in the top module.

## Test plan
- **Reset.** Hold `rst` 3 cycles with `req_valid`=1 → `csb0`=1, `web0`=1, `addr0`=0, `din0`=0, `rsp_valid`=0, `req_ready`=0; no macro access.
- **Write then read.** Write addr 5 data 2'b10; next cycle read addr 5 → `csb0` low for exactly 2 consecutive cycles; `rsp_valid` 2 cycles after the read accept with `rsp_rdata`=2'b10.
- **Streaming reads.** Fill addrs 0..15 with addr[1:0], then 16 back-to-back reads with `rsp_ready`=1 → `req_ready` never drops; 16 responses in order, each equal to addr[1:0], one per cycle.
- **Backpressure.** `rsp_ready`=0 while issuing reads → exactly 4 accepted, then `req_ready`=0; raise `rsp_ready` → 4 correct responses in order; no loss or duplication.
- **Mixed traffic.** Read A, write B, read C interleaved with `rsp_ready` toggling every cycle → exactly 2 responses (A then C); the write produces none.
- **Mid-operation reset.** `rst` pulsed 1 cycle while 2 reads are in flight and 1 response is queued → `rsp_valid`=0 the cycle after; no stale response ever appears; the next read returns correct data with 2-cycle latency.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the OpenRAM 1RW port controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DATA_W = 2;
  localparam int unsigned SRAM_ADDR_W = 4;
  localparam int unsigned SRAM_RD_LAT = 2;
  localparam int unsigned SRAM_OCC_W  = $clog2(SRAM_RD_LAT + 1);

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic                   valid;
    logic [SRAM_DATA_W-1:0] rdata;
  } sram_rsp_t;

  // Number of reads currently travelling through the macro read pipe.
  function automatic logic [SRAM_OCC_W-1:0] pipe_occupancy(input logic [SRAM_RD_LAT-1:0] pipe);
    pipe_occupancy = '0;
    for (int i = 0; i < SRAM_RD_LAT; i++) begin
      pipe_occupancy = pipe_occupancy + SRAM_OCC_W'(pipe[i]);
    end
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO; head is visible while non-empty, data masked to 0 when empty.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid  = (count != '0);
  assign data   = valid ? mem[rd_ptr] : '0;
  assign do_pop = pop & valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready front-end for a 1RW OpenRAM macro: registered issue stage, read tracking and
// credit-gated response FIFO so that no read result is ever dropped.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [SRAM_RD_LAT-1:0] rd_pipe;
  logic [CNT_W-1:0]       fifo_count;
  logic [CRD_W-1:0]       credit_used;
  logic                   accept;
  logic                   rd_issue;

  // Reads in the macro pipe already own a FIFO slot; a pop only frees credit next cycle.
  assign credit_used = CRD_W'(fifo_count) + CRD_W'(pipe_occupancy(rd_pipe));
  assign req_ready   = ~rst & (credit_used < CRD_W'(RSP_DEPTH));
  assign accept      = req_valid & req_ready;
  assign rd_issue    = accept & ~req_we;

  always_ff @(posedge clk0) begin
    if (rst) begin
      csb0    <= 1'b1;
      web0    <= 1'b1;
      addr0   <= '0;
      din0    <= '0;
      rd_pipe <= '0;
    end else begin
      csb0    <= ~accept;
      web0    <= ~(accept & req_we);
      rd_pipe <= {rd_pipe[SRAM_RD_LAT-2:0], rd_issue};
      if (accept) begin
        addr0 <= req_addr;
        din0  <= req_wdata;
      end
    end
  end

  // dout0 is only valid around the edge closing the rd_pipe[last] cycle, so push exactly then.
  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk0),
    .rst       (rst),
    .push      (rd_pipe[SRAM_RD_LAT-1]),
    .push_data (dout0),
    .pop       (rsp_ready),
    .valid     (rsp_valid),
    .data      (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench: behavioural 1RW macro, directed vector table, corner sequences and random traffic.
module tb_sram_port_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned DW    = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk0 = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk0 = ~clk0;

  sram_port_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk0      (clk0),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Macro model: captures on posedge, accesses the array on the following negedge,
  // and scrambles dout0 shortly after the next posedge (hold time expired).
  logic [DW-1:0] mac_mem [16];
  logic          mac_cs = 1'b0;
  logic          mac_we = 1'b0;
  logic [AW-1:0] mac_addr = '0;
  logic [DW-1:0] mac_din = '0;

  always begin
    @(posedge clk0);
    mac_cs   = (csb0 === 1'b0);
    mac_we   = (web0 === 1'b0);
    mac_addr = addr0;
    mac_din  = din0;
    #1 dout0 = ~dout0;
    @(negedge clk0);
    if (mac_cs) begin
      if (mac_we) mac_mem[mac_addr] = mac_din;
      else        dout0 = mac_mem[mac_addr];
    end
  end

  // Reference model: memory image updated at accept time, a queue of expected responses
  // with the cycle at which each becomes visible, and an outstanding-read count for credit.
  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } exp_rsp_t;

  logic [DW-1:0] ref_mem [16];
  exp_rsp_t      rq[$];
  int            outstanding = 0;
  int            cyc = 0;
  bit            live = 1'b0;
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;

  int   n_pops = 0;
  int   n_rd_acc = 0;
  int   stall_cnt = 0;
  int   pop_cycles[$];
  bit   hs_last = 1'b0;
  logic p_v = 1'b0, p_rdy = 1'b0, p_rst = 1'b1, p_we = 1'b0;
  logic [AW-1:0] p_a = '0;
  logic [DW-1:0] p_d = '0;

  always @(posedge clk0) begin
    bit ev_pre;
    bit acc;
    ev_pre = (rq.size() != 0) && (rq[0].vis <= cyc);
    if (rsp_valid === 1'b1 && rsp_ready) begin
      n_pops++;
      pop_cycles.push_back(cyc);
    end
    if (req_valid && req_ready === 1'b1 && !req_we) n_rd_acc++;
    if (req_valid && req_ready !== 1'b1 && !rst) stall_cnt++;
    hs_last = req_valid && (req_ready === 1'b1);
    if (p_v && !p_rdy && !p_rst) begin
      total++;
      assert (req_valid && req_we == p_we && req_addr == p_a && req_wdata == p_d)
      else begin
        bad++;
        $display("FAIL req_hold: request changed while stalled at %0t", $time);
      end
    end
    p_v = req_valid; p_rdy = (req_ready === 1'b1); p_rst = rst;
    p_we = req_we; p_a = req_addr; p_d = req_wdata;

    cyc++;
    if (rst) begin
      live = 1'b1;
      rq.delete();
      outstanding = 0;
      m_csb = 1'b1; m_web = 1'b1; m_addr = '0; m_din = '0;
    end else begin
      acc = req_valid && (outstanding < DEPTH);
      if (ev_pre && rsp_ready) begin
        void'(rq.pop_front());
        outstanding--;
      end
      if (acc) begin
        m_csb = 1'b0; m_web = ~req_we; m_addr = req_addr; m_din = req_wdata;
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
        end else begin
          rq.push_back('{data: ref_mem[req_addr], vis: cyc + 2});
          outstanding++;
        end
      end else begin
        m_csb = 1'b1; m_web = 1'b1;
      end
    end
  end

  always @(negedge clk0) begin
    bit ev;
    #2;
    if (live) begin
      ev = (rq.size() != 0) && (rq[0].vis <= cyc);
      chk("m_req_ready", 32'(req_ready), 32'(!rst && (outstanding < DEPTH)));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("m_rsp_rdata", 32'(rsp_rdata), ev ? 32'(rq[0].data) : 32'd0);
      chk("m_csb0", 32'(csb0), 32'(m_csb));
      chk("m_web0", 32'(web0), 32'(m_web));
      chk("m_addr0", 32'(addr0), 32'(m_addr));
      chk("m_din0", 32'(din0), 32'(m_din));
    end
  end

  // Directed vector table: inputs for one cycle plus the outputs expected during that cycle.
  typedef struct {
    logic          rst;
    sram_req_t     req;
    logic          rr;
    logic          e_rdy;
    logic          e_csb;
    logic          e_web;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    sram_rsp_t     e_rsp;
  } vec_t;

  function automatic vec_t mk(input logic r, v, we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic rr, erdy, ecsb, eweb, input logic [AW-1:0] eaddr,
                              input logic [DW-1:0] edin, input logic erv, input logic [DW-1:0] erd);
    mk.rst = r;
    mk.req = '{valid: v, we: we, addr: a, wdata: d};
    mk.rr = rr; mk.e_rdy = erdy; mk.e_csb = ecsb; mk.e_web = eweb;
    mk.e_addr = eaddr; mk.e_din = edin;
    mk.e_rsp = '{valid: erv, rdata: erd};
  endfunction

  task automatic step(input logic r, v, we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    @(negedge clk0);
    rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, rr);
  endtask

  // Present a request and hold it until accepted (bounded wait).
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk0);
    rst = 1'b0; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    while (req_ready !== 1'b1 && waited < 64) begin
      @(negedge clk0);
      #1;
      waited++;
    end
    if (req_ready !== 1'b1) chk("send_timeout", 32'(req_ready), 32'd1);
    @(posedge clk0);
  endtask

  vec_t vecs[9];

  initial begin
    int p0, pops0, acc0, stall0;
    for (int i = 0; i < 16; i++) begin
      mac_mem[i] = '0;
      ref_mem[i] = '0;
    end

    vecs[0] = mk(1, 1, 1, 4'd3, 2'd1, 0,  0, 1, 1, 4'd0, 2'd0, 0, 2'd0);
    vecs[1] = mk(1, 1, 1, 4'd3, 2'd1, 0,  0, 1, 1, 4'd0, 2'd0, 0, 2'd0);
    vecs[2] = mk(1, 1, 1, 4'd3, 2'd1, 0,  0, 1, 1, 4'd0, 2'd0, 0, 2'd0);
    vecs[3] = mk(0, 1, 1, 4'd5, 2'd2, 1,  1, 1, 1, 4'd0, 2'd0, 0, 2'd0);
    vecs[4] = mk(0, 1, 0, 4'd5, 2'd0, 1,  1, 0, 0, 4'd5, 2'd2, 0, 2'd0);
    vecs[5] = mk(0, 0, 0, 4'd0, 2'd0, 1,  1, 0, 1, 4'd5, 2'd0, 0, 2'd0);
    vecs[6] = mk(0, 0, 0, 4'd0, 2'd0, 1,  1, 1, 1, 4'd5, 2'd0, 0, 2'd0);
    vecs[7] = mk(0, 0, 0, 4'd0, 2'd0, 1,  1, 1, 1, 4'd5, 2'd0, 1, 2'd2);
    vecs[8] = mk(0, 0, 0, 4'd0, 2'd0, 1,  1, 1, 1, 4'd5, 2'd0, 0, 2'd0);

    @(posedge clk0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk0);
      rst = vecs[i].rst; req_valid = vecs[i].req.valid; req_we = vecs[i].req.we;
      req_addr = vecs[i].req.addr; req_wdata = vecs[i].req.wdata; rsp_ready = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_csb0", i), 32'(csb0), 32'(vecs[i].e_csb));
      chk($sformatf("v%0d_web0", i), 32'(web0), 32'(vecs[i].e_web));
      chk($sformatf("v%0d_addr0", i), 32'(addr0), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_din0", i), 32'(din0), 32'(vecs[i].e_din));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp.valid));
      chk($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rsp.rdata));
    end

    // Streaming: fill with addr[1:0], then 16 back-to-back reads drained at full rate.
    idle(1, 1'b1);
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i));
    p0 = pop_cycles.size();
    stall0 = stall_cnt;
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0);
    idle(6, 1'b1);
    chk("stream_pops", 32'(pop_cycles.size() - p0), 32'd16);
    if (pop_cycles.size() >= p0 + 16)
      chk("stream_span", 32'(pop_cycles[p0 + 15] - pop_cycles[p0]), 32'd15);
    chk("stream_stalls", 32'(stall_cnt - stall0), 32'd0);

    // Backpressure: credit stops at RSP_DEPTH reads, then drains in order.
    idle(1, 1'b0);
    pops0 = n_pops;
    acc0 = n_rd_acc;
    for (int i = 8; i < 12; i++) send(1'b0, AW'(i), '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'd12, '0, 1'b0);
    #1;
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_accepted", 32'(n_rd_acc - acc0), 32'd4);
    @(negedge clk0);
    rsp_ready = 1'b1;
    send(1'b0, 4'd12, '0);
    idle(8, 1'b1);
    chk("bp_pops", 32'(n_pops - pops0), 32'd5);

    // Mixed traffic with rsp_ready toggling every cycle.
    pops0 = n_pops;
    step(1'b0, 1'b1, 1'b0, 4'd1, '0,   1'b1);
    step(1'b0, 1'b1, 1'b1, 4'd2, 2'd3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd4, '0,   1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, '0, '0, (i % 2) == 0 ? 1'b0 : 1'b1);
    chk("mixed_pops", 32'(n_pops - pops0), 32'd2);

    // Mid-operation reset with two reads in flight and one response queued.
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    #1;
    chk("rst_flush_rsp_valid", 32'(rsp_valid), 32'd0);
    pops0 = n_pops;
    idle(4, 1'b1);
    chk("rst_no_stale", 32'(n_pops - pops0), 32'd0);
    send(1'b0, 4'd2, '0);
    idle(4, 1'b1);
    chk("rst_next_read", 32'(n_pops - pops0), 32'd1);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk0);
      rst = ($urandom_range(0, 79) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (!(req_valid && !hs_last)) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = $urandom_range(0, 1) == 1;
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end
    end
    idle(8, 1'b1);
    chk("final_drained", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
